// File: rtl/pc_sequencer.sv
// Purpose : registered fetch PC with sequential / J / JAL / JR / BEQ / BNE redirect arbitration.
// Latency : a redirect presented with stall=0 appears on pc one cycle later.
// Backpressure: stall freezes pc. A redirect seen under stall is parked and applied on release.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   stall                       hazard hold. PC frozen; a pending redirect may still be captured or upgraded.
//   id_pc, jump, instr_index    ID-stage J/JAL
//   jr, jr_target               ID-stage JR with forwarded rs
//   ex_pc, branch_beq/bne, zero, br_imm   EX-stage resolved conditional branch
//   pc, pc_plus4                fetch PC (registered) and its successor (combinational)
//   flush_if, flush_id          kill strobes for IF/ID and ID/EX (combinational)
//   redirect_pending            a parked redirect waits for stall release
//   misalign                    JR target not word aligned (only with MISALIGN_TRAP_EN)
//
// Build option: define MISALIGN_TRAP_EN to send misaligned JRs to TRAP_PC and drive misalign.
module pc_sequencer #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0080
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic              jump,
  input  logic [25:0]       instr_index,
  input  logic              jr,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              branch_beq,
  input  logic              branch_bne,
  input  logic              zero,
  input  logic [31:0]       br_imm,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              flush_if,
  output logic              flush_id,
  output logic              redirect_pending,
  output logic              misalign
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Priority classes: larger value wins. Branch kills two stages, ID redirects one.
  localparam logic [1:0] CLS_NONE = 2'd0;
  localparam logic [1:0] CLS_JUMP = 2'd1;
  localparam logic [1:0] CLS_JR   = 2'd2;
  localparam logic [1:0] CLS_BR   = 2'd3;

  localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic [1:0]        pend_cls_q, pend_cls_d;

  // Target computation
  logic [31:0]       imm_sh;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] id_pc_p4;
  logic [ADDR_W-1:0] jmp_tgt;
  logic [ADDR_W-1:0] jr_tgt;
  logic              br_taken;
  logic              jr_mis;

  assign imm_sh   = {br_imm[29:0], 2'b00};
  assign br_tgt   = ex_pc + FOUR + imm_sh[ADDR_W-1:0];
  assign id_pc_p4 = id_pc + FOUR;
  assign jmp_tgt  = {id_pc_p4[ADDR_W-1:28], instr_index, 2'b00};

  // BEQ and BNE together is illegal encoding; suppress rather than guess.
  assign br_taken = ((branch_beq & zero) | (branch_bne & ~zero)) & ~(branch_beq & branch_bne);

`ifdef MISALIGN_TRAP_EN
  assign jr_mis = jr & (jr_target[1:0] != 2'b00);
  assign jr_tgt = jr_mis ? TRAP_PC[ADDR_W-1:0] : {jr_target[ADDR_W-1:2], 2'b00};
`else
  assign jr_mis = 1'b0;
  assign jr_tgt = {jr_target[ADDR_W-1:2], 2'b00};
`endif

  assign misalign = jr_mis;

  // Bits that are architecturally ignored in some configurations.
  logic unused_bits;
  assign unused_bits = ^{br_imm[31:30], id_pc_p4[27:0], jr_target[1:0], TRAP_PC};

  // Winning redirect this cycle
  logic [1:0]        req_cls;
  logic [ADDR_W-1:0] req_tgt;

  always_comb begin
    req_cls = CLS_NONE;
    req_tgt = '0;
    if (br_taken) begin
      req_cls = CLS_BR;
      req_tgt = br_tgt;
    end else if (jr) begin
      req_cls = CLS_JR;
      req_tgt = jr_tgt;
    end else if (jump) begin
      req_cls = CLS_JUMP;
      req_tgt = jmp_tgt;
    end
  end

  assign pc_plus4 = pc_q + FOUR;

  // Next-state and flush decision
  logic flush_if_c;
  logic flush_id_c;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    pend_cls_d = pend_cls_q;
    flush_if_c = 1'b0;
    flush_id_c = 1'b0;
    case (state_q)
      RUN: begin
        if (!stall) begin
          if (req_cls != CLS_NONE) begin
            pc_d       = req_tgt;
            flush_if_c = 1'b1;
            flush_id_c = (req_cls == CLS_BR);
          end else begin
            pc_d = pc_plus4;
          end
        end else if (req_cls != CLS_NONE) begin
          pend_tgt_d = req_tgt;
          pend_cls_d = req_cls;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (stall) begin
          // Only a strictly older (higher-priority) redirect can replace the parked one.
          if (req_cls > pend_cls_q) begin
            pend_tgt_d = req_tgt;
            pend_cls_d = req_cls;
          end
        end else begin
          // Redirect inputs on the release cycle come from the wrong path.
          pc_d       = pend_tgt_q;
          flush_if_c = 1'b1;
          flush_id_c = (pend_cls_q == CLS_BR);
          pend_cls_d = CLS_NONE;
          state_d    = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC[ADDR_W-1:0];
      pend_tgt_q <= '0;
      pend_cls_q <= CLS_NONE;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      pend_cls_q <= pend_cls_d;
    end
  end

  assign pc               = pc_q;
  assign flush_if         = flush_if_c;
  assign flush_id         = flush_id_c;
  assign redirect_pending = (state_q == HOLD);

endmodule

// File: tb/tb_pc_sequencer.sv
// Purpose : self-checking bench for pc_sequencer; directed vectors with a queue-based scoreboard.
// Latency : one expectation per cycle, checked on the falling edge of the same cycle.
// Backpressure: none; stimulus never waits on the monitor except for the final drain.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] id_pc = '0;
  logic        jump = 1'b0;
  logic [25:0] instr_index = '0;
  logic        jr = 1'b0;
  logic [31:0] jr_target = '0;
  logic [31:0] ex_pc = '0;
  logic        branch_beq = 1'b0;
  logic        branch_bne = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] br_imm = '0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        flush_if;
  logic        flush_id;
  logic        redirect_pending;
  logic        misalign;

  pc_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .id_pc            (id_pc),
    .jump             (jump),
    .instr_index      (instr_index),
    .jr               (jr),
    .jr_target        (jr_target),
    .ex_pc            (ex_pc),
    .branch_beq       (branch_beq),
    .branch_bne       (branch_bne),
    .zero             (zero),
    .br_imm           (br_imm),
    .pc               (pc),
    .pc_plus4         (pc_plus4),
    .flush_if         (flush_if),
    .flush_id         (flush_id),
    .redirect_pending (redirect_pending),
    .misalign         (misalign)
  );

  always #5 clk = ~clk;

`ifdef MISALIGN_TRAP_EN
  localparam logic        MIS    = 1'b1;
  localparam logic [31:0] JR_EXP = 32'h0000_0080;
`else
  localparam logic        MIS    = 1'b0;
  localparam logic [31:0] JR_EXP = 32'h0000_0200;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic        fi;
    logic        fid;
    logic        pend;
    logic        mis;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, want);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      chk(n, "pc",       pc,               e.pc);
      chk(n, "pc_plus4", pc_plus4,         e.pc + 32'd4);
      chk(n, "flush_if", {31'd0, flush_if}, {31'd0, e.fi});
      chk(n, "flush_id", {31'd0, flush_id}, {31'd0, e.fid});
      chk(n, "pending",  {31'd0, redirect_pending}, {31'd0, e.pend});
      chk(n, "misalign", {31'd0, misalign}, {31'd0, e.mis});
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    stall      = 1'b0;
    jump       = 1'b0;
    jr         = 1'b0;
    branch_beq = 1'b0;
    branch_bne = 1'b0;
    zero       = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [31:0] p, input logic fi, input logic fid,
                            input logic pend, input logic mis);
    exp_t e;
    e = '{pc: p, fi: fi, fid: fid, pend: pend, mis: mis};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic set_jump(input logic [31:0] ipc, input logic [25:0] idx);
    jump = 1'b1; id_pc = ipc; instr_index = idx;
  endtask

  task automatic set_branch(input logic beq, input logic z, input logic [31:0] epc, input logic [31:0] imm);
    branch_beq = beq; branch_bne = ~beq; zero = z; ex_pc = epc; br_imm = imm;
  endtask

  initial begin
    next_cycle(); rst_n = 1'b0;
    expect_out("reset", 32'h0, 0, 0, 0, 0);

    next_cycle(); rst_n = 1'b1;
    expect_out("seq0", 32'h0, 0, 0, 0, 0);
    next_cycle(); expect_out("seq1", 32'h4, 0, 0, 0, 0);
    next_cycle(); expect_out("seq2", 32'h8, 0, 0, 0, 0);
    next_cycle(); expect_out("seq3", 32'hC, 0, 0, 0, 0);

    // 0x40 + 4 - 8 = 0x3C
    next_cycle(); set_branch(1, 1, 32'h40, 32'hFFFF_FFFE);
    expect_out("beq_taken", 32'h10, 1, 1, 0, 0);
    next_cycle(); set_branch(1, 0, 32'h40, 32'hFFFF_FFFE);
    expect_out("beq_not_taken", 32'h3C, 0, 0, 0, 0);

    // BNE taken: 0x0C + 4 + 12 = 0x1C beats the jump to 0x1000_0400
    next_cycle(); set_jump(32'h1000_0010, 26'h100); set_branch(0, 0, 32'h0C, 32'd3);
    expect_out("br_over_jump", 32'h40, 1, 1, 0, 0);
    next_cycle(); expect_out("br_target", 32'h1C, 0, 0, 0, 0);

    next_cycle(); set_jump(32'h1000_0010, 26'h100);
    expect_out("jump_only", 32'h20, 1, 0, 0, 0);
    next_cycle(); expect_out("jump_target", 32'h1000_0400, 0, 0, 0, 0);

    // Stall with jump to 0x400, then branch to 0x80 (0x40+4+60) overrides it.
    next_cycle(); stall = 1'b1; set_jump(32'h0, 26'h100);
    expect_out("stall_capture", 32'h1000_0404, 0, 0, 0, 0);
    next_cycle(); stall = 1'b1; set_branch(1, 1, 32'h40, 32'd15);
    expect_out("hold_overwrite", 32'h1000_0404, 0, 0, 1, 0);
    next_cycle(); stall = 1'b1; set_jump(32'h0, 26'h100);
    expect_out("hold_lower_ignored", 32'h1000_0404, 0, 0, 1, 0);
    next_cycle(); jr = 1'b1; jr_target = 32'h300;
    expect_out("release", 32'h1000_0404, 1, 1, 1, 0);
    next_cycle(); expect_out("released_pc", 32'h80, 0, 0, 0, 0);

    next_cycle(); jr = 1'b1; jr_target = 32'h202;
    expect_out("jr_misalign", 32'h84, 1, 0, 0, MIS);
    next_cycle(); expect_out("jr_target", JR_EXP, 0, 0, 0, 0);

    // Park a JR, then reset while in HOLD.
    next_cycle(); stall = 1'b1; jr = 1'b1; jr_target = 32'h202;
    expect_out("misalign_stalled", JR_EXP + 32'd4, 0, 0, 0, MIS);
    next_cycle(); stall = 1'b1;
    expect_out("hold_pending", JR_EXP + 32'd4, 0, 0, 1, 0);
    next_cycle(); stall = 1'b1; rst_n = 1'b0;
    expect_out("reset_in_hold", 32'h0, 0, 0, 0, 0);
    next_cycle(); rst_n = 1'b1;
    expect_out("after_reset", 32'h0, 0, 0, 0, 0);

    next_cycle(); jr = 1'b1; jr_target = 32'hFFFF_FFFC;
    expect_out("jr_wrap", 32'h4, 1, 0, 0, 0);
    next_cycle(); expect_out("wrap_pc", 32'hFFFF_FFFC, 0, 0, 0, 0);
    next_cycle(); expect_out("wrap_zero", 32'h0, 0, 0, 0, 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      $fatal(1, "scoreboard did not drain");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Registered program-counter unit for the 5-stage pipelined core; successor to the single-cycle next-PC logic.
- Owns the PC register and arbitrates sequential fetch, ID-stage J/JAL and JR redirects, and EX-stage resolved BEQ/BNE redirects.
- Holds the PC under stall and latches a redirect that arrives during a stall, applying it on release.
- Drives IF/ID and ID/EX flush strobes.

Parameters:
- ADDR_W, 32, PC width in bits (legal 30..32).
- RESET_PC, 32'h0000_0000, PC value loaded on reset (low ADDR_W bits used).
- TRAP_PC, 32'h0000_0080, redirect target for a misaligned JR (used only with MISALIGN_TRAP_EN).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hazard-unit hold; PC and pending state frozen except pending capture
- id_pc  in  ADDR_W  PC of the instruction in ID
- jump  in  1  ID holds J/JAL
- instr_index  in  26  J-format target field
- jr  in  1  ID holds JR
- jr_target  in  ADDR_W  forwarded rs value
- ex_pc  in  ADDR_W  PC of the instruction in EX
- branch_beq  in  1  EX holds BEQ
- branch_bne  in  1  EX holds BNE
- zero  in  1  ALU zero flag for the EX instruction
- br_imm  in  32  sign-extended branch offset (word units)
- pc  out  ADDR_W  current fetch PC (registered)
- pc_plus4  out  ADDR_W  pc+4 (combinational)
- flush_if  out  1  kill the instruction entering IF/ID
- flush_id  out  1  kill the instruction entering ID/EX
- redirect_pending  out  1  a latched redirect awaits stall release
- misalign  out  1  JR target low bits nonzero (feature-dependent)

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, pending valid=0, pending target=0. Combinational outputs are then flush_if=0, flush_id=0, redirect_pending=0, misalign=0.
- Targets (all arithmetic mod 2^ADDR_W):
  - branch target BT = ex_pc + 4 + (br_imm << 2)
  - jump target JT = {(id_pc+4)[ADDR_W-1:28], instr_index, 2'b00}
  - JR target = jr_target with bits [1:0] forced to 00.
- Branch taken: (branch_beq & zero) | (branch_bne & ~zero). branch_beq and branch_bne both 1 is illegal; treat it as not taken.
- Redirect priority, highest first: branch taken (EX) > jr (ID) > jump (ID) > sequential pc+4.
- State machine, 2 states:
  - RUN, stall=0:
    - pc <= winning target, or pc+4 if no redirect.
    - Branch taken: flush_if=1, flush_id=1.
    - jr or jump alone: flush_if=1 only.
    - No redirect: no flush.
  - RUN, stall=1:
    - pc holds, no flush.
    - If a redirect is present, capture the winning target into the pending register and go to HOLD.
  - HOLD, stall=1:
    - pc holds.
    - A new redirect of strictly higher priority than the captured one overwrites target and priority. Equal or lower priority is ignored.
  - HOLD, stall=0 (release):
    - pc <= pending target.
    - Flushes are driven per the captured priority class.
    - Redirect inputs this cycle are ignored (wrong-path).
    - Return to RUN.
- redirect_pending = 1 exactly while in HOLD.
- Flushes are combinational from the current-cycle decision; never asserted while stall=1.
- Reset mid-HOLD discards the pending redirect.
- pc wrap: 32'hFFFF_FFFC + 4 = 0, no flag.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- When defined:
  - misalign = jr & (jr_target[1:0] != 0).
  - A misaligned JR redirects to TRAP_PC instead of its target, with jr priority.
  - Flush_if behaves as for jr.
  - misalign is valid in the same cycle as the JR, including while stall=1.
- When undefined: misalign is tied 0 and the low bits are forced to 00 as above.

Test Plan:
- Reset release, no redirects, stall=0 for 4 cycles -> pc 0,4,8,12; flushes 0.
- ex_pc=0x40, branch_beq=1, zero=1, br_imm=-2 -> next pc=0x3C; flush_if=1, flush_id=1. Same with zero=0 -> pc+4, no flush.
- Same cycle: jump (id_pc=0x1000_0010, instr_index=0x0000100) and bne taken (ex_pc=0x0C, br_imm=3) -> pc=0x1C; branch wins.
- stall=1 with jump to 0x400 -> pc held, redirect_pending=1. Next cycle, still stalled, branch taken to 0x80 -> pending overwritten to 0x80. Release -> pc=0x80, both flushes=1, pending=0.
- Assert rst_n=0 while in HOLD -> pc=RESET_PC immediately; redirect_pending=0 after release.
- MISALIGN_TRAP_EN defined: jr, jr_target=0x202 -> misalign=1, pc=0x80. Undefined: pc=0x200, misalign=0.
